// File: rtl/mips_alu_unit.sv
// Execute-stage arithmetic for the multicycle MIPS core: ALU control decode,
// 32-bit ALU with zero flag, branch-target adder, and the ALUOut register.
module mips_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] offset_in,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] add_out,
    output logic [WIDTH-1:0] alu_out_q,
    output logic             zero_q
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_SLL  = 4'b0100;
    localparam logic [3:0] CTRL_SRL  = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SRA  = 4'b1000;
    localparam logic [3:0] CTRL_SLTU = 4'b1001;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_INV  = 4'b1111;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        alu_ctrl = CTRL_INV;
        case (alu_op)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b11: alu_ctrl = CTRL_OR;
            default: begin
                case (func_code)
                    6'h20, 6'h21: alu_ctrl = CTRL_ADD;
                    6'h22, 6'h23: alu_ctrl = CTRL_SUB;
                    6'h24:        alu_ctrl = CTRL_AND;
                    6'h25:        alu_ctrl = CTRL_OR;
                    6'h26:        alu_ctrl = CTRL_XOR;
                    6'h27:        alu_ctrl = CTRL_NOR;
                    6'h2A:        alu_ctrl = CTRL_SLT;
                    6'h2B:        alu_ctrl = CTRL_SLTU;
                    6'h00:        alu_ctrl = CTRL_SLL;
                    6'h02:        alu_ctrl = CTRL_SRL;
                    6'h03:        alu_ctrl = CTRL_SRA;
                    default:      alu_ctrl = CTRL_INV;
                endcase
            end
        endcase
    end

    // Add/sub wrap silently; undecoded control codes yield zero.
    always_comb begin
        result = '0;
        case (alu_ctrl)
            CTRL_AND:  result = a & b;
            CTRL_OR:   result = a | b;
            CTRL_XOR:  result = a ^ b;
            CTRL_NOR:  result = ~(a | b);
            CTRL_ADD:  result = a + b;
            CTRL_SUB:  result = a - b;
            CTRL_SLT:  result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            CTRL_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            CTRL_SLL:  result = b << shamt;
            CTRL_SRL:  result = b >> shamt;
            CTRL_SRA:  result = $unsigned(b_s >>> shamt);
            default:   result = '0;
        endcase
    end

    assign zero    = (result == '0);
    assign add_out = pc_in + offset_in;

    // ALUOut register: zero_q resets high to stay consistent with a zero result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            alu_out_q <= result;
            zero_q    <= zero;
        end
    end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Bench for mips_alu_unit: directed boundary steps plus randomized operations
// checked against an instruction-level reference model.
module tb_mips_alu_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  func_code;
    logic [4:0]  shamt;
    logic [31:0] a, b, pc_in, offset_in;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] add_out;
    logic [31:0] alu_out_q;
    logic        zero_q;

    int compared = 0;
    int mismatched = 0;

    mips_alu_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .func_code(func_code),
        .shamt(shamt), .a(a), .b(b), .pc_in(pc_in), .offset_in(offset_in),
        .alu_ctrl(alu_ctrl), .result(result), .zero(zero), .add_out(add_out),
        .alu_out_q(alu_out_q), .zero_q(zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the instruction means, expressed as (control code, value).
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (fn)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h26: return 4'b0011;
            6'h27: return 4'b1100;
            6'h2A: return 4'b0111;
            6'h2B: return 4'b1001;
            6'h00: return 4'b0100;
            6'h02: return 4'b0101;
            6'h03: return 4'b1000;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [5:0] fn,
                                               input logic [4:0] sh, input logic [31:0] x,
                                               input logic [31:0] y);
        logic [31:0] fill;
        fill = y[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        if (op == 2'b00) return x + y;
        if (op == 2'b01) return x - y;
        if (op == 2'b11) return x | y;
        case (fn)
            6'h20, 6'h21: return x + y;
            6'h22, 6'h23: return x - y;
            6'h24: return x & y;
            6'h25: return x | y;
            6'h26: return x ^ y;
            6'h27: return ~(x | y);
            6'h2A: return (x[31] != y[31]) ? {31'h0, x[31]} : {31'h0, (x < y)};
            6'h2B: return {31'h0, (x < y)};
            6'h00: return y << sh;
            6'h02: return y >> sh;
            6'h03: return (y >> sh) | fill;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] pc, input logic [31:0] off);
        alu_op = op; func_code = fn; shamt = sh; a = x; b = y; pc_in = pc; offset_in = off;
        #1;
    endtask

    // Directed step: literal expected result plus model-derived control code.
    task automatic step(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res);
        drive(op, fn, sh, x, y, 32'h0, 32'h0);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, {31'h0, zero}, {31'h0, (exp_res == 32'h0)});
        check({tag, "_ctrl"}, {28'h0, alu_ctrl}, {28'h0, ref_ctrl(op, fn)});
    endtask

    logic [5:0]  valid_fn [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                   6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02};
    logic [31:0] exp_q;

    initial begin
        reset = 1'b0;
        drive(2'b00, 6'h00, 5'd0, 32'd1, 32'd2, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_alu_out_q", alu_out_q, 32'h0);
        check("reset_zero_q", {31'h0, zero_q}, 32'h1);
        check("reset_comb_result", result, 32'd3);

        // Decode sweep
        step("dec_op00", 2'b00, 6'h3F, 5'd0, 32'd1, 32'd1, 32'd2);
        check("dec_op00_code", {28'h0, alu_ctrl}, 32'h2);
        step("dec_op01", 2'b01, 6'h3F, 5'd0, 32'd9, 32'd4, 32'd5);
        check("dec_op01_code", {28'h0, alu_ctrl}, 32'h6);
        step("dec_op11", 2'b11, 6'h3F, 5'd0, 32'hF0, 32'h0F, 32'hFF);
        check("dec_op11_code", {28'h0, alu_ctrl}, 32'h1);
        step("dec_slt", 2'b10, 6'h2A, 5'd0, 32'd1, 32'd2, 32'd1);
        check("dec_slt_code", {28'h0, alu_ctrl}, 32'h7);
        step("dec_invalid", 2'b10, 6'h3F, 5'd0, 32'h1234, 32'h5678, 32'h0);
        check("dec_invalid_code", {28'h0, alu_ctrl}, 32'hF);

        // Arithmetic wrap, compare, logic
        step("add_wrap", 2'b10, 6'h20, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        step("sub_eq", 2'b10, 6'h22, 5'd0, 32'd5, 32'd5, 32'h0);
        step("sub_wrap", 2'b10, 6'h23, 5'd0, 32'd0, 32'd1, 32'hFFFF_FFFF);
        step("slt_neg", 2'b10, 6'h2A, 5'd0, 32'h8000_0000, 32'd1, 32'd1);
        step("sltu_big", 2'b10, 6'h2B, 5'd0, 32'h8000_0000, 32'd1, 32'd0);
        step("nor_zero", 2'b10, 6'h27, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        step("xor", 2'b10, 6'h26, 5'd0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0);
        step("and", 2'b10, 6'h24, 5'd0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000);

        // Shifts
        step("sll4", 2'b10, 6'h00, 5'd4, 32'h0, 32'h8000_0001, 32'h0000_0010);
        step("srl4", 2'b10, 6'h02, 5'd4, 32'h0, 32'h8000_0001, 32'h0800_0000);
        step("sra4", 2'b10, 6'h03, 5'd4, 32'h0, 32'h8000_0001, 32'hF800_0000);
        step("sll0", 2'b10, 6'h00, 5'd0, 32'h0, 32'h8000_0001, 32'h8000_0001);
        step("sra0", 2'b10, 6'h03, 5'd0, 32'h0, 32'h8000_0001, 32'h8000_0001);
        step("sra31", 2'b10, 6'h03, 5'd31, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Branch adder
        drive(2'b10, 6'h3F, 5'd0, 32'h0, 32'h0, 32'h0000_0010, 32'h0000_0040);
        check("badd_simple", add_out, 32'h0000_0050);
        drive(2'b01, 6'h00, 5'd3, 32'h7, 32'h9, 32'hFFFF_FFFC, 32'h0000_0008);
        check("badd_wrap_op01", add_out, 32'h0000_0004);
        drive(2'b11, 6'h20, 5'd9, 32'hAA, 32'h55, 32'hFFFF_FFFC, 32'h0000_0008);
        check("badd_wrap_op11", add_out, 32'h0000_0004);

        // Registered stage and reset (still held in reset here)
        @(negedge clk);
        reset = 1'b1;
        drive(2'b00, 6'h00, 5'd0, 32'd3, 32'd4, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("reg_add_q", alu_out_q, 32'd7);
        check("reg_add_zero_q", {31'h0, zero_q}, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_q", alu_out_q, 32'h0);
        check("async_reset_zero_q", {31'h0, zero_q}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        drive(2'b01, 6'h00, 5'd0, 32'd10, 32'd3, 32'h0, 32'h0);
        #1;
        check("release_hold_q", alu_out_q, 32'h0);
        @(posedge clk);
        #1;
        check("release_capture_q", alu_out_q, 32'd7);
        check("release_capture_zero_q", {31'h0, zero_q}, 32'h0);

        // Randomized operations
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            @(negedge clk);
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else if ($urandom_range(0, 5) == 0) fn = 6'h03;
            else fn = valid_fn[$urandom_range(0, 11)];
            drive(op, fn, 5'($urandom), $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                  $urandom, $urandom);
            exp_q = ref_result(op, fn, shamt, a, b);
            check("rnd_ctrl", {28'h0, alu_ctrl}, {28'h0, ref_ctrl(op, fn)});
            check("rnd_result", result, exp_q);
            check("rnd_zero", {31'h0, zero}, {31'h0, (exp_q == 32'h0)});
            check("rnd_add_out", add_out, pc_in + offset_in);
            @(posedge clk);
            #1;
            check("rnd_alu_out_q", alu_out_q, exp_q);
            check("rnd_zero_q", {31'h0, zero_q}, {31'h0, (exp_q == 32'h0)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_alu_unit.md
Name: mips_alu_unit

Overview:
- Execute-stage arithmetic block of the multicycle MIPS core (mips_cpu_bus).
- Merges three functions: the ALU control decoder (ALUOp plus funct to a 4-bit ALU control code), the main 32-bit ALU with zero flag, and the branch-target adder (PC plus shifted offset).
- Combinational results feed the datapath directly. A registered copy (ALUOut register) holds the result across FSM states.

Parameters:
- WIDTH, 32, datapath width; only 32 is required to be supported.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- alu_op  in  2  ALUOp from control_unit.
- func_code  in  6  instr[5:0].
- shamt  in  5  instr[10:6], shift amount.
- a  in  32  operand A (register read_data1).
- b  in  32  operand B (read_data2 or extended immediate).
- pc_in  in  32  current PC.
- offset_in  in  32  shifted branch offset.
- alu_ctrl  out  4  decoded ALU control code (combinational).
- result  out  32  ALU result (combinational).
- zero  out  1  high when result == 0 (combinational).
- add_out  out  32  pc_in + offset_in (combinational).
- alu_out_q  out  32  result registered on rising clk.
- zero_q  out  1  zero registered on rising clk.

Behaviour:
- Decoder, by alu_op:
  - 00 gives ADD 0010.
  - 01 gives SUB 0110.
  - 11 gives OR 0001, used for ori.
  - 10 decodes func_code:
    - 0x20/0x21 ADD 0010
    - 0x22/0x23 SUB 0110
    - 0x24 AND 0000
    - 0x25 OR 0001
    - 0x26 XOR 0011
    - 0x27 NOR 1100
    - 0x2A SLT 0111
    - 0x2B SLTU 1001
    - 0x00 SLL 0100
    - 0x02 SRL 0101
    - 0x03 SRA 1000
    - any other funct gives INVALID 1111.
- ALU operations:
  - AND: a&b.
  - OR: a|b.
  - XOR: a^b.
  - NOR: ~(a|b).
  - ADD: a+b modulo 2^32.
  - SUB: a-b modulo 2^32.
  - SLT: 1 if a<b signed, else 0.
  - SLTU: 1 if a<b unsigned, else 0.
  - SLL: b<<shamt.
  - SRL: b>>shamt, logical.
  - SRA: b>>>shamt, sign-filled.
  - Any unlisted control code, including 1111: result 0.
- Arithmetic rules: no overflow detection or trap; add and addu behave identically, sub and subu identically.
- zero = (result == 32'h0), evaluated for every operation.
- add_out = pc_in + offset_in, wraps modulo 2^32. It is independent of alu_op and the operands.
- All combinational outputs settle within the same cycle; no latency.
- Registered stage:
  - On every rising clk, alu_out_q <= result and zero_q <= zero. There is no enable; the register updates every cycle.
  - Latency from operands to alu_out_q is 1 cycle.
- Reset: on reset low, immediately and asynchronously, alu_out_q = 0 and zero_q = 1 (kept consistent with a zero result). Combinational outputs are unaffected by reset.
- Reset mid-operation clears the registers regardless of clk. Release is synchronous to the next rising edge, after which registers capture normally.
- Boundary requirements:
  - shamt = 0 passes b unchanged.
  - SRA of 0x80000000 by 31 gives 0xFFFFFFFF.
  - SLT of 0x80000000 vs 0x00000001 gives 1.
  - SLTU of the same operands gives 0.

Test Plan:
- Decode sweep: alu_op=00 gives alu_ctrl 0010; alu_op=01 gives 0110; alu_op=11 gives 0001; alu_op=10 with funct 0x2A gives 0111; alu_op=10 with funct 0x3F gives 1111 and result 0.
- Arithmetic wrap: ADD a=0xFFFFFFFF, b=1 gives result 0, zero=1. SUB a=5, b=5 gives 0, zero=1. SUB a=0, b=1 gives 0xFFFFFFFF, zero=0.
- Compare and logic: SLT a=0x80000000, b=1 gives 1; SLTU gives 0. NOR a=0, b=0 gives 0xFFFFFFFF. XOR a=0xF0F0F0F0, b=0xFFFF0000 gives 0x0F0FF0F0.
- Shifts: b=0x80000001 with shamt=4 gives SLL 0x00000010, SRL 0x08000000, SRA 0xF8000000. shamt=0 gives b unchanged.
- Branch adder: pc_in=0x00000010 and offset_in=0x00000040 give add_out 0x00000050. pc_in=0xFFFFFFFC and offset_in=8 give 0x00000004, regardless of alu_op.
- Register and reset: ADD 3+4 appears on alu_out_q=7, zero_q=0 after one rising edge. Asserting reset low between edges forces alu_out_q=0, zero_q=1 immediately. After release, the next edge captures the live result.
